// File: rtl/addfield_pkg.sv
// addfield_pkg: mode constants and FSM state encoding shared by the
// addfield field inserter/overwriter and its testbench.
package addfield_pkg;

    localparam logic AF_INSERT    = 1'b0;
    localparam logic AF_OVERWRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HEAD  = 3'd1,
        ST_FIELD = 3'd2,
        ST_TAIL  = 3'd3,
        ST_DRAIN = 3'd4
    } af_state_t;

endpackage

// File: rtl/addfield_bytedelay.sv
// bytedelay: i_ce-gated shift register of {valid, byte} slots. The oldest
// slot is presented on the outputs; o_empty is high when no slot holds a
// valid byte.
module bytedelay #(
    parameter int DEPTH = 6
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ce,
    input  logic       i_v,
    input  logic [7:0] i_byte,
    output logic       o_v,
    output logic [7:0] o_byte,
    output logic       o_empty
);

    logic [8:0] stage [DEPTH];

    // Shift one {valid, byte} slot per tick, newest entering at stage 0
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= 9'h000;
            end
        end else if (i_ce) begin
            stage[0] <= {i_v, i_byte};
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    // Line is empty when no slot carries a valid byte
    always_comb begin
        o_empty = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            o_empty = o_empty & ~stage[i][8];
        end
    end

    assign o_v    = stage[DEPTH-1][8];
    assign o_byte = stage[DEPTH-1][7:0];

endmodule

// File: rtl/addfield.sv
// addfield: inserts or overwrites an FLDBYTES-wide field at byte OFFSET of
// each packet in an i_ce-qualified byte stream. Enable, mode and field are
// latched at packet start. Bytes arriving after the current packet has ended
// but before the engine is idle are discarded as a whole packet (o_drop).
// Optional macro ADDFIELD_STATS_EN adds packet/drop counters o_pkts/o_drops.
module addfield
    import addfield_pkg::*;
#(
    parameter int OFFSET   = 6,
    parameter int FLDBYTES = 6
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_ce,
    input  logic                    i_en,
    input  logic                    i_mode,
    input  logic [8*FLDBYTES-1:0]   i_field,
    input  logic                    i_v,
    input  logic [7:0]              i_byte,
    output logic                    o_v,
    output logic [7:0]              o_byte,
    output logic                    o_busy,
    output logic                    o_drop
`ifdef ADDFIELD_STATS_EN
    ,
    output logic [31:0]             o_pkts,
    output logic [15:0]             o_drops
`endif
);

    localparam int CW = $clog2(OFFSET + FLDBYTES + 2);
    localparam int FW = (FLDBYTES < 2) ? 1 : $clog2(FLDBYTES + 1);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] OFF_C   = CW'(OFFSET);
    localparam logic [CW-1:0] WEND_C  = CW'(OFFSET + FLDBYTES);
    localparam logic [FW-1:0] FLAST_C = FW'(FLDBYTES - 1);

    // Byte idx of the field, counted from the most significant byte
    function automatic logic [7:0] field_byte(input logic [8*FLDBYTES-1:0] fld, input int idx);
        logic [8*FLDBYTES-1:0] sh;
        sh = fld << (8 * idx);
        return sh[8*FLDBYTES-1 -: 8];
    endfunction

    af_state_t               state_r, state_next;
    logic [CW-1:0]           cnt_r, cnt_next, cur_pos;
    logic [FW-1:0]           fidx_r, fidx_next;
    logic                    en_r, mode_r, ended_r, ended_next, discard_r, discard_next;
    logic [8*FLDBYTES-1:0]   field_r, cur_field;
    logic                    cur_en, cur_mode, start_s, ins_here_s, ow_here_s;
    logic                    v_next, drop_next, push_v_s;
    logic [7:0]              byte_next, ow_byte_s, push_byte_s;
    logic                    dly_v_s, dly_empty_s;
    logic [7:0]              dly_byte_s;

    // In IDLE the live inputs describe the packet that may start this tick
    assign cur_en    = (state_r == ST_IDLE) ? i_en    : en_r;
    assign cur_mode  = (state_r == ST_IDLE) ? i_mode  : mode_r;
    assign cur_field = (state_r == ST_IDLE) ? i_field : field_r;
    assign cur_pos   = (state_r == ST_IDLE) ? {CW{1'b0}} : cnt_r;

    assign start_s    = (state_r == ST_IDLE) && i_v && !discard_r;
    assign ins_here_s = cur_en && (cur_mode == AF_INSERT) && (cur_pos == OFF_C);
    assign ow_here_s  = cur_en && (cur_mode == AF_OVERWRITE) &&
                        (cur_pos >= OFF_C) && (cur_pos < WEND_C);
    assign ow_byte_s  = field_byte(cur_field, int'(cur_pos - OFF_C));
    assign push_byte_s = push_v_s ? i_byte : 8'h00;
    assign o_busy      = (state_r != ST_IDLE);

    bytedelay #(.DEPTH(FLDBYTES)) u_delay (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .i_v     (push_v_s),
        .i_byte  (push_byte_s),
        .o_v     (dly_v_s),
        .o_byte  (dly_byte_s),
        .o_empty (dly_empty_s)
    );

    // Next-state, next-output and delay-line push decisions for one tick
    always_comb begin
        state_next   = state_r;
        cnt_next     = cnt_r;
        fidx_next    = fidx_r;
        ended_next   = ended_r;
        discard_next = discard_r & i_v;
        v_next       = 1'b0;
        byte_next    = 8'h00;
        drop_next    = 1'b0;
        push_v_s     = 1'b0;
        case (state_r)
            ST_IDLE, ST_HEAD: begin
                ended_next = 1'b0;
                if (!i_v) begin
                    state_next = ST_IDLE;
                end else if ((state_r == ST_IDLE) && discard_r) begin
                    state_next = ST_IDLE;
                end else if (ins_here_s) begin
                    v_next     = 1'b1;
                    byte_next  = field_byte(cur_field, 0);
                    push_v_s   = 1'b1;
                    fidx_next  = FW'(1);
                    state_next = (FLDBYTES == 1) ? ST_TAIL : ST_FIELD;
                end else begin
                    v_next     = 1'b1;
                    byte_next  = ow_here_s ? ow_byte_s : i_byte;
                    cnt_next   = (cur_pos == CNT_MAX) ? CNT_MAX : cur_pos + CW'(1);
                    state_next = ST_HEAD;
                end
            end
            ST_FIELD: begin
                v_next     = 1'b1;
                byte_next  = field_byte(field_r, int'(fidx_r));
                fidx_next  = fidx_r + FW'(1);
                push_v_s   = i_v && !ended_r;
                ended_next = ended_r | ~i_v;
                if (i_v && ended_r && !discard_r) begin
                    drop_next    = 1'b1;
                    discard_next = 1'b1;
                end else begin
                    drop_next    = 1'b0;
                end
                if (fidx_r == FLAST_C) begin
                    state_next = (ended_r || !i_v) ? ST_DRAIN : ST_TAIL;
                end else begin
                    state_next = ST_FIELD;
                end
            end
            ST_TAIL: begin
                v_next     = dly_v_s;
                byte_next  = dly_byte_s;
                push_v_s   = i_v;
                state_next = i_v ? ST_TAIL : ST_DRAIN;
            end
            ST_DRAIN: begin
                v_next    = dly_v_s;
                byte_next = dly_byte_s;
                if (i_v && !discard_r) begin
                    drop_next    = 1'b1;
                    discard_next = 1'b1;
                end else begin
                    drop_next    = 1'b0;
                end
                state_next = dly_empty_s ? ST_IDLE : ST_DRAIN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, packet context and registered outputs advance only on ticks
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            fidx_r    <= {FW{1'b0}};
            en_r      <= 1'b0;
            mode_r    <= AF_INSERT;
            field_r   <= {(8*FLDBYTES){1'b0}};
            ended_r   <= 1'b0;
            discard_r <= 1'b0;
            o_v       <= 1'b0;
            o_byte    <= 8'h00;
            o_drop    <= 1'b0;
        end else if (i_ce) begin
            state_r   <= state_next;
            cnt_r     <= cnt_next;
            fidx_r    <= fidx_next;
            ended_r   <= ended_next;
            discard_r <= discard_next;
            o_v       <= v_next;
            o_byte    <= byte_next;
            o_drop    <= drop_next;
            if (start_s) begin
                en_r    <= i_en;
                mode_r  <= i_mode;
                field_r <= i_field;
            end
        end else begin
            o_drop <= 1'b0;
        end
    end

`ifdef ADDFIELD_STATS_EN
    // Wrapping counters of modified packets and rejected packets
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pkts  <= 32'd0;
            o_drops <= 16'd0;
        end else if (i_ce) begin
            if (start_s && i_en) begin
                o_pkts <= o_pkts + 32'd1;
            end
            if (drop_next) begin
                o_drops <= o_drops + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_addfield.sv
// tb_addfield: directed self-checking bench for addfield (OFFSET=6, FLDBYTES=6).
module tb_addfield;

    localparam logic [47:0] FIELD = 48'h0102_0304_0506;
    localparam logic [7:0] FLD_B [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

    logic        clk = 1'b0;
    logic        i_reset, i_ce, i_en, i_mode, i_v;
    logic [47:0] i_field;
    logic [7:0]  i_byte;
    logic        o_v, o_busy, o_drop;
    logic [7:0]  o_byte;

    always #5 clk = ~clk;

    addfield #(.OFFSET(6), .FLDBYTES(6)) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_ce    (i_ce),
        .i_en    (i_en),
        .i_mode  (i_mode),
        .i_field (i_field),
        .i_v     (i_v),
        .i_byte  (i_byte),
        .o_v     (o_v),
        .o_byte  (o_byte),
        .o_busy  (o_busy),
        .o_drop  (o_drop)
    );

    // Output monitor: records valid bytes and their tick numbers
    logic       tick_seen = 1'b0;
    logic [7:0] outq [$];
    int         outt [$];
    int         ticks = 0;
    int         busy_last = 0;
    int         drops = 0;

    always @(posedge clk) tick_seen <= i_ce;

    always @(negedge clk) begin
        if (o_drop) drops++;
        if (tick_seen) begin
            ticks++;
            if (o_v) begin
                outq.push_back(o_byte);
                outt.push_back(ticks);
            end
            if (o_busy) busy_last = ticks;
        end
    end

    int         n_checks = 0;
    int         n_fail = 0;
    bit         half_rate = 1'b0;
    int         start_tick = 0;
    int         base = 0;
    int         d0 = 0;
    logic [7:0] expq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One tick with the given input byte; half rate adds an idle clock first
    task automatic tick(input logic v, input logic [7:0] b);
        if (half_rate) begin
            @(negedge clk); #1;
            i_ce = 1'b0; i_v = v; i_byte = b;
        end
        @(negedge clk); #1;
        i_ce = 1'b1; i_v = v; i_byte = b;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'h00);
    endtask

    // Packet of len bytes first, first+1, ...; at byte live_at the
    // per-packet controls are flipped while the packet is in flight
    task automatic send_pkt(input int len, input logic [7:0] first, input int live_at);
        for (int i = 0; i < len; i++) begin
            tick(1'b1, first + 8'(i));
            if (i == 0) start_tick = ticks + 1;
            if (i == live_at) begin
                i_en    = ~i_en;
                i_mode  = ~i_mode;
                i_field = 48'hDEAD_BEEF_CAFE;
            end
        end
        tick(1'b0, 8'h00);
    endtask

    // Expected output byte stream for one packet
    function automatic void build_exp(input bit en, input bit mode, input int len, input logic [7:0] first);
        logic [7:0] b;
        expq.delete();
        for (int p = 0; p < len; p++) begin
            b = first + 8'(p);
            if (en && mode && p >= 6 && p < 12) b = FLD_B[p-6];
            if (en && !mode && p == 6) begin
                for (int k = 0; k < 6; k++) expq.push_back(FLD_B[k]);
            end
            expq.push_back(b);
        end
    endfunction

    // Compare captured bytes from index b0 against expq, contiguous from tick t0
    task automatic chk_seq(input string tag, input int b0, input int t0);
        chk({tag, " length"}, 32'(outq.size() - b0), 32'(expq.size()));
        for (int i = 0; i < expq.size(); i++) begin
            if (b0 + i < outq.size()) begin
                chk($sformatf("%s byte%0d", tag, i), 32'(outq[b0+i]), 32'(expq[i]));
                chk($sformatf("%s tick%0d", tag, i), 32'(outt[b0+i]), 32'(t0 + i));
            end
        end
    endtask

    initial begin
        i_reset = 1'b1; i_ce = 1'b0; i_en = 1'b0; i_mode = 1'b0;
        i_field = FIELD; i_v = 1'b0; i_byte = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("reset o_v",    32'(o_v),    32'd0);
        chk("reset o_byte", 32'(o_byte), 32'd0);
        chk("reset o_busy", 32'(o_busy), 32'd0);
        chk("reset o_drop", 32'(o_drop), 32'd0);
        i_reset = 1'b0;
        idle(2);

        // 1: insert, 20 bytes, controls flipped mid-packet
        i_en = 1'b1; i_mode = 1'b0; i_field = FIELD;
        base = outq.size();
        send_pkt(20, 8'h10, 3);
        idle(10);
        build_exp(1'b1, 1'b0, 20, 8'h10);
        chk_seq("t1 insert", base, start_tick);
        chk("t1 busy last", 32'(busy_last), 32'(start_tick + 25));
        chk("t1 idle", 32'(o_busy), 32'd0);

        // 2: overwrite, 20 bytes
        i_en = 1'b1; i_mode = 1'b1; i_field = FIELD;
        base = outq.size();
        send_pkt(20, 8'h10, -1);
        idle(4);
        build_exp(1'b1, 1'b1, 20, 8'h10);
        chk_seq("t2 overwrite", base, start_tick);

        // 3: pass-through with i_en toggled mid-packet
        i_en = 1'b0; i_mode = 1'b0; i_field = FIELD;
        base = outq.size();
        send_pkt(20, 8'h10, 5);
        idle(4);
        build_exp(1'b0, 1'b0, 20, 8'h10);
        chk_seq("t3 passthru", base, start_tick);

        // 4: insert, short packets
        i_en = 1'b1; i_mode = 1'b0; i_field = FIELD;
        base = outq.size();
        send_pkt(4, 8'h10, -1);
        idle(4);
        build_exp(1'b1, 1'b0, 4, 8'h10);
        chk_seq("t4 len4", base, start_tick);
        chk("t4 len4 idle", 32'(o_busy), 32'd0);
        base = outq.size();
        send_pkt(8, 8'h10, -1);
        idle(10);
        build_exp(1'b1, 1'b0, 8, 8'h10);
        chk_seq("t4 len8", base, start_tick);
        chk("t4 len8 idle", 32'(o_busy), 32'd0);

        // 5: second packet during DRAIN is dropped, next one processed
        i_en = 1'b1; i_mode = 1'b0; i_field = FIELD;
        base = outq.size();
        d0 = drops;
        send_pkt(20, 8'h10, -1);
        for (int i = 0; i < 5; i++) tick(1'b1, 8'hA0 + 8'(i));
        tick(1'b0, 8'h00);
        idle(10);
        build_exp(1'b1, 1'b0, 20, 8'h10);
        chk_seq("t5 first", base, start_tick);
        chk("t5 drop count", 32'(drops - d0), 32'd1);
        chk("t5 idle", 32'(o_busy), 32'd0);
        base = outq.size();
        send_pkt(8, 8'h40, -1);
        idle(10);
        build_exp(1'b1, 1'b0, 8, 8'h40);
        chk_seq("t5 next", base, start_tick);

        // 6a: insert at half rate
        half_rate = 1'b1;
        base = outq.size();
        send_pkt(20, 8'h10, -1);
        idle(10);
        build_exp(1'b1, 1'b0, 20, 8'h10);
        chk_seq("t6 halfrate", base, start_tick);
        half_rate = 1'b0;

        // 6b: reset after byte 9 enters, then a clean packet
        for (int i = 0; i < 9; i++) tick(1'b1, 8'h10 + 8'(i));
        @(negedge clk); #1;
        chk("t6 pre-reset o_v", 32'(o_v), 32'd1);
        i_reset = 1'b1;
        #1;
        chk("t6 reset o_v",    32'(o_v),    32'd0);
        chk("t6 reset o_byte", 32'(o_byte), 32'd0);
        chk("t6 reset o_busy", 32'(o_busy), 32'd0);
        i_v = 1'b0;
        @(negedge clk); #1;
        i_reset = 1'b0;
        base = outq.size();
        send_pkt(20, 8'h10, -1);
        idle(10);
        build_exp(1'b1, 1'b0, 20, 8'h10);
        chk_seq("t6 after reset", base, start_tick);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addfield.md
Name: addfield

Overview:
- Parametrised successor to the fixed 6-byte MAC inserter in the Ethernet TX byte path.
- Operates on a byte stream qualified by `i_ce`. At a configurable byte offset it does one of two things to each packet:
  - inserts an `FLDBYTES`-wide field (stream grows by `FLDBYTES`), or
  - overwrites `FLDBYTES` bytes in place (length unchanged).
- Sits between the packet source and the CRC/preamble stages. Mode, enable and field are latched per packet.

Parameters:
- `OFFSET`, default 6: byte index (0 = first byte) at which the field starts; range 0..63.
- `FLDBYTES`, default 6: field length in bytes; range 1..16.

Ports:
- `i_clk`  in  1  single clock
- `i_reset`  in  1  asynchronous active-high reset
- `i_ce`  in  1  byte strobe; all state advances only when high
- `i_en`  in  1  1 = modify packet, 0 = pass through; sampled at packet start
- `i_mode`  in  1  0 = insert, 1 = overwrite; sampled at packet start
- `i_field`  in  8*FLDBYTES  field value; MSB byte is emitted first; sampled at packet start
- `i_v`  in  1  input byte valid, held high for the whole packet
- `i_byte`  in  8  input byte
- `o_v`  out  1  output byte valid
- `o_byte`  out  8  output byte
- `o_busy`  out  1  high from packet start until the last output byte is emitted
- `o_drop`  out  1  one-`i_clk` pulse when a packet is rejected

Behaviour:
- **Reset and clock enable**
  - Async reset clears all state. Outputs reset to: `o_v`=0, `o_byte`=8'h00, `o_busy`=0, `o_drop`=0.
  - A "tick" means an `i_clk` edge with `i_ce`=1. Without `i_ce`, every register holds, except `o_drop`, which clears.
- **Packet start**
  - Start occurs on a tick with `i_v`=1 while `o_busy`=0.
  - At start, latch `i_en`, `i_mode` and `i_field`. Clear the position counter.
  - The counter saturates, at width `$clog2(OFFSET+FLDBYTES+2)`.
- **FSM states:** IDLE, HEAD, FIELD, TAIL, DRAIN.
  - Pass-through (latched enable = 0): IDLE→HEAD at start; HEAD→IDLE when `i_v` falls.
  - Overwrite mode: states as for pass-through (HEAD, then back to IDLE).
  - Insert mode: IDLE→HEAD at start. HEAD→FIELD at position `OFFSET` (or immediately if `OFFSET`=0). FIELD→TAIL after `FLDBYTES` ticks. TAIL→DRAIN when `i_v` falls. DRAIN→IDLE when the delay line is empty.
- **Pass-through timing:** latency is 1 tick; `o_byte` = previous `i_byte`, `o_v` = previous `i_v`.
- **Overwrite mode**
  - Latency is 1 tick.
  - Output bytes at positions `OFFSET`..`OFFSET+FLDBYTES-1` take the field bytes, MSB first. All other bytes pass unchanged.
  - If the packet ends inside the window, only the bytes present are overwritten; length is unchanged.
- **Insert mode**
  - Bytes 0..`OFFSET-1` leave with 1-tick latency.
  - Then `FLDBYTES` field bytes are emitted with `o_v`=1 regardless of `i_v`.
  - Then input bytes from position `OFFSET` onward leave through an `FLDBYTES`-deep delay line.
  - Total output length = input length + `FLDBYTES`.
- **Short packets in insert mode**
  - Input ending before position `OFFSET` (length < `OFFSET`): packet passes unchanged, no field is appended, return to IDLE.
  - Input ending during FIELD: the full field is still emitted, then the buffered bytes.
- **Busy and rejection**
  - `o_busy` = (state != IDLE).
  - `i_v`=1 on a tick while `o_busy`=1 and the current input packet has already ended (DRAIN): the whole incoming packet is discarded until `i_v` falls. `o_drop` pulses once, and the discarded bytes never reach the output.
- **Live input changes:** changes to `i_field`, `i_en` or `i_mode` mid-packet have no effect.
- **Reset mid-packet:** output stops immediately and the next packet starts clean.

Optional Feature:
- Macro: `ADDFIELD_STATS_EN`.
- When defined, adds outputs:
  - `o_pkts` [31:0]: counts packets modified (latched enable = 1).
  - `o_drops` [15:0]: counts `o_drop` pulses.
  - Both counters wrap and are cleared by reset.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package `addfield_pkg`:
  - mode constants `AF_INSERT`=1'b0, `AF_OVERWRITE`=1'b1;
  - state encoding for IDLE/HEAD/FIELD/TAIL/DRAIN.
- One sub-module, `bytedelay`:
  - parameter `DEPTH`; `i_ce`-gated shift register of {valid, byte};
  - outputs the delayed {valid, byte} and an `empty` flag;
  - instantiated with `DEPTH`=`FLDBYTES`.

Test Plan (`OFFSET`=6, `FLDBYTES`=6, `i_field`=48'h0102_0304_0506, `i_ce`=1 unless stated):
1. Insert mode, 20-byte packet with bytes 8'h10..8'h23:
   - Output is 26 bytes: 10..15, 01..06, 16..23.
   - `o_v` is contiguous; `o_busy` falls 1 tick after the last byte.
2. Overwrite mode, same packet:
   - Output is 20 bytes: 10..15, 01..06, 1C..23.
   - Latency is exactly 1 tick.
3. `i_en`=0, same packet:
   - Output is identical to input, delayed 1 tick.
   - Toggling `i_en` mid-packet has no effect.
4. Insert, short packets:
   - 4-byte packet → 4 bytes unchanged.
   - 8-byte packet → 10..15, 01..06, 16, 17 (14 bytes).
5. Insert, back-to-back:
   - Second packet `i_v` rises during DRAIN → `o_drop` pulses once and the second packet is absent from output.
   - Next packet started after `o_busy`=0 → processed normally.
6. Test 1 again, stressed:
   - Run with `i_ce` high only every other clock → same byte sequence.
   - Assert reset at byte 9 → outputs 0 immediately; the next packet is correct.
